theta_stage: RTL and testbench
==============================

# theta_stage

Second stage of the 5x5x64 lane pipeline: accepts 25 lanes streamed from the input stage's m1 read path (x fastest, then y), stores them in the m2 lane memory while accumulating the five column parities, then computes the theta column mix and streams the 25 theta-mixed lanes to the next stage under backpressure. It sits directly downstream of the input/m1 loader and drives that loader's `m1_stopout`.

## Interface
Parameters
- `W`, 64, lane width in bits
- `N`, 5, lanes per row/column (x, y range 0..N-1)

Ports
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; synchronous, active-low (asserted when 0)
- `pushin`  in  1  lane valid from upstream
- `firstin`  in  1  marks lane (0,0) of a frame
- `din`  in  W  lane data, valid with `pushin`
- `stopin`  out  1  to upstream `m1_stopout`; high = do not push
- `m2wx`, `m2wy`  out  3  m2 write address
- `m2wd`  out  W  m2 write data
- `m2wr`  out  1  m2 write enable
- `m2rx`, `m2ry`  out  3  m2 read address (combinational read, data same cycle)
- `m2rd`  in  W  m2 read data
- `pushout`  out  1  output lane valid
- `firstout`  out  1  marks output lane (0,0)
- `dout`  out  W  theta-mixed lane
- `stopout`  in  1  downstream backpressure; high = hold

## Operation
- States: LOAD, CALC, DRAIN.
- Reset (rst=0 at a clock edge): state LOAD; counters wx=wy=rx=ry=0; C[0..4]=0; D[0..4]=0; m2wr=0, m2wx=m2wy=0, m2wd=0; pushout=firstout=0; stopin=0. Applies from any state, including mid-frame or mid-DRAIN; the partial frame is discarded.
- LOAD: stopin=0. Lane accepted when pushin=1.
  - pushin&firstin: lane stored at (0,0); C[x]=din for x=0, C[1..4]=0; next index (1,0). Applies also mid-frame (restart).
  - pushin&!firstin before any firstin since reset/last frame: dropped, no write.
  - pushin&!firstin in frame: stored at current (wx,wy); C[wx]^=din; wx wraps 4->0 with wy+1.
  - Acceptance of (4,4) -> CALC.
- Writes are registered: m2wr/m2wx/m2wy/m2wd presented the cycle after acceptance, m2wr=0 otherwise.
- CALC (one cycle): stopin=1; D[x] = C[(x+4) mod 5] ^ rotl(C[(x+1) mod 5], 1), rotl is a 64-bit circular left shift by 1 (bit 63 -> bit 0). -> DRAIN.
- DRAIN: stopin=1; m2rx=rx, m2ry=ry; dout = m2rd ^ D[rx]; pushout = !stopout; firstout = pushout & (rx==0 & ry==0).
  - stopout=1: rx/ry hold, pushout=0, no lane consumed.
  - Transfer of (4,4) -> LOAD, rx=ry=0.
- pushin while stopin=1: ignored, no write, no parity update.
- m2rx/m2ry = 0 outside DRAIN.

## Timing
- Lane (4,4) accepted at cycle N: its m2 write at N+1 (CALC); DRAIN from N+2.
- With stopout held low: output lanes at N+2..N+26, (0,0) first with firstout; LOAD and stopin=0 at N+27.
- Each stopout-high cycle in DRAIN adds exactly one cycle; no lane lost or duplicated.
- stopin is a function of registered state only.
- pushout/firstout/dout are combinational from state, rx/ry, D, m2rd and stopout; downstream samples them on the same edge.
- Minimum frame period: 25 load + 1 calc + 25 drain = 51 cycles.

## Structure
- Shared package `lane_pkg`: `W`, `N`, state typedef `theta_state_t {T_LOAD, T_CALC, T_DRAIN}`, 3-bit index type, constant for last index (4).
- Sub-module `theta_d_gen`: combinational, inputs C[0..4], outputs D[0..4] including the mod-5 neighbour selection and rotl.
- Top holds FSM, index counters, parity registers, m2 write pipeline register.

## Test plan
- All 25 lanes 0 -> 25 outputs of 0, firstout only on first, stopin low again 27 cycles after last input.
- A(0,0)=1, others 0 -> outputs: (0,0)=1, all x=1 lanes=1, all x=4 lanes=2, rest 0.
- A(2,0)=0x8000_0000_0000_0000, others 0 -> x=1 lanes=1, x=3 lanes=0x8000_0000_0000_0000, (2,0)=0x8000_0000_0000_0000, rest 0 (rotl wrap).
- Lanes A(x,y)=5y+x+1, stopout high 3 cycles at output lane 7 -> lane 7 held, exactly 25 pushout pulses, drain takes 28 cycles.
- firstin re-asserted at lane 10 then full 25 -> output matches the second frame only; pushin without prior firstin after reset -> dropped, m2wr stays 0.
- rst=0 during DRAIN lane 12 -> next cycle pushout=0, stopin=0, m2wr=0; fresh frame then processes correctly.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared types and constants for the 5x5 lane pipeline stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lane_pkg;

   // Lane width in bits and lanes per row/column.
   localparam int W = 64;
   localparam int N = 5;

   // Lane coordinate (x or y), wide enough for 0..N-1.
   typedef logic [2:0] idx_t;

   // Coordinate of the last lane in a row/column.
   localparam idx_t LAST_IDX = idx_t'(N - 1);

   // Theta stage sequencing: fill the lane memory, derive D, stream out.
   typedef enum logic [1:0] {
      T_LOAD  = 2'd0,
      T_CALC  = 2'd1,
      T_DRAIN = 2'd2
   } theta_state_t;

endpackage

// File: rtl/theta_d_gen.sv
// Theta column-mix term D[x] = C[x-1] ^ rotl(C[x+1], 1), indices mod N.
// Latency: combinational.
// Backpressure: none; pure function of the column parities.
// Ports: c[0..N-1] column parities in, d[0..N-1] mix terms out.
module theta_d_gen #(
   parameter int W = lane_pkg::W,
   parameter int N = lane_pkg::N
) (
   input  logic [W-1:0] c [N],
   output logic [W-1:0] d [N]
);

   for (genvar x = 0; x < N; x++) begin : g_col
      // Neighbour columns resolved at elaboration; no runtime modulo.
      localparam int XM = (x + N - 1) % N;
      localparam int XP = (x + 1) % N;
      assign d[x] = c[XM] ^ {c[XP][W-2:0], c[XP][W-1]};
   end

endmodule

// File: rtl/theta_stage.sv
// Theta stage: stores 25 lanes into m2 while folding column parities, then streams theta-mixed lanes.
// Latency: last lane accepted at cycle N -> first output at N+2, 25 outputs, back to LOAD at N+27.
// Backpressure: stopin high outside LOAD; stopout stalls the drain one cycle per high cycle.
// Ports: clk/rst (sync, active-low); pushin/firstin/din/stopin upstream; m2w*/m2r* lane memory;
//        pushout/firstout/dout/stopout downstream.
module theta_stage #(
   parameter int W = lane_pkg::W,
   parameter int N = lane_pkg::N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pushin,
   input  logic         firstin,
   input  logic [W-1:0] din,
   output logic         stopin,
   output logic [2:0]   m2wx,
   output logic [2:0]   m2wy,
   output logic [W-1:0] m2wd,
   output logic         m2wr,
   output logic [2:0]   m2rx,
   output logic [2:0]   m2ry,
   input  logic [W-1:0] m2rd,
   output logic         pushout,
   output logic         firstout,
   output logic [W-1:0] dout,
   input  logic         stopout
);

   import lane_pkg::*;

   theta_state_t state_q, state_d;

   idx_t wx_q, wy_q;
   idx_t rx_q, ry_q;
   // Set by a firstin lane; non-first lanes outside a frame are dropped.
   logic in_frame_q;

   logic [W-1:0] c_q   [N];
   logic [W-1:0] d_q   [N];
   logic [W-1:0] d_nxt [N];

   logic accept;

   theta_d_gen #(.W(W), .N(N)) u_d_gen (
      .c (c_q),
      .d (d_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= T_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stopin   = 1'b1;
      accept   = 1'b0;
      m2rx     = '0;
      m2ry     = '0;
      pushout  = 1'b0;
      firstout = 1'b0;
      dout     = '0;
      case (state_q)
         T_LOAD: begin
            stopin = 1'b0;
            accept = pushin && (firstin || in_frame_q);
            // A firstin lane always lands at (0,0), so it can never close a frame.
            if (accept && !firstin && wx_q == LAST_IDX && wy_q == LAST_IDX) begin
               state_d = T_CALC;
            end
         end
         T_CALC: begin
            state_d = T_DRAIN;
         end
         T_DRAIN: begin
            m2rx     = rx_q;
            m2ry     = ry_q;
            dout     = m2rd ^ d_q[rx_q];
            pushout  = !stopout;
            firstout = !stopout && rx_q == '0 && ry_q == '0;
            if (!stopout && rx_q == LAST_IDX && ry_q == LAST_IDX) begin
               state_d = T_LOAD;
            end
         end
         default: begin
            state_d = T_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wx_q       <= '0;
         wy_q       <= '0;
         rx_q       <= '0;
         ry_q       <= '0;
         in_frame_q <= 1'b0;
         m2wr       <= 1'b0;
         m2wx       <= '0;
         m2wy       <= '0;
         m2wd       <= '0;
         for (int i = 0; i < N; i++) begin
            c_q[i] <= '0;
            d_q[i] <= '0;
         end
      end else begin
         m2wr <= accept;
         if (accept) begin
            m2wd <= din;
            if (firstin) begin
               m2wx       <= '0;
               m2wy       <= '0;
               wx_q       <= idx_t'(1);
               wy_q       <= '0;
               in_frame_q <= 1'b1;
               c_q[0]     <= din;
               for (int i = 1; i < N; i++) begin
                  c_q[i] <= '0;
               end
            end else begin
               m2wx       <= wx_q;
               m2wy       <= wy_q;
               c_q[wx_q]  <= c_q[wx_q] ^ din;
               if (wx_q == LAST_IDX) begin
                  wx_q <= '0;
                  if (wy_q == LAST_IDX) begin
                     wy_q       <= '0;
                     in_frame_q <= 1'b0;
                  end else begin
                     wy_q <= wy_q + idx_t'(1);
                  end
               end else begin
                  wx_q <= wx_q + idx_t'(1);
               end
            end
         end

         if (state_q == T_CALC) begin
            for (int i = 0; i < N; i++) begin
               d_q[i] <= d_nxt[i];
            end
            rx_q <= '0;
            ry_q <= '0;
         end

         if (state_q == T_DRAIN && pushout) begin
            if (rx_q == LAST_IDX) begin
               rx_q <= '0;
               ry_q <= (ry_q == LAST_IDX) ? '0 : ry_q + idx_t'(1);
            end else begin
               rx_q <= rx_q + idx_t'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_theta_stage.sv
// Bench for theta_stage: lane-memory model, scoreboard of expected output lanes.
// Latency: n/a.
// Backpressure: stopout driven by the stimulus thread.
module tb_theta_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pushin, firstin;
   logic [63:0] din;
   logic        stopin;
   logic [2:0]  m2wx, m2wy, m2rx, m2ry;
   logic [63:0] m2wd, m2rd;
   logic        m2wr;
   logic        pushout, firstout;
   logic [63:0] dout;
   logic        stopout;

   always #5 clk = ~clk;

   theta_stage dut (
      .clk      (clk),
      .rst      (rst),
      .pushin   (pushin),
      .firstin  (firstin),
      .din      (din),
      .stopin   (stopin),
      .m2wx     (m2wx),
      .m2wy     (m2wy),
      .m2wd     (m2wd),
      .m2wr     (m2wr),
      .m2rx     (m2rx),
      .m2ry     (m2ry),
      .m2rd     (m2rd),
      .pushout  (pushout),
      .firstout (firstout),
      .dout     (dout),
      .stopout  (stopout)
   );

   // m2 lane memory: registered write, combinational read.
   logic [63:0] mem [64];
   always @(posedge clk) if (m2wr) mem[{m2wy, m2wx}] <= m2wd;
   assign m2rd = mem[{m2ry, m2rx}];

   typedef struct packed {
      logic [63:0] d;
      logic        f;
   } exp_t;
   typedef logic [63:0] frame_t [25];

   exp_t sb [$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   out_count = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rotl1(input logic [63:0] v);
      return (v << 1) | (v >> 63);
   endfunction

   function automatic void push_exp(input logic [63:0] d, input logic f);
      exp_t e;
      e.d = d;
      e.f = f;
      sb.push_back(e);
   endfunction

   function automatic void push_model(input frame_t a);
      logic [63:0] c [5];
      logic [63:0] dm [5];
      for (int x = 0; x < 5; x++) begin
         c[x] = '0;
         for (int y = 0; y < 5; y++) c[x] ^= a[5*y + x];
      end
      for (int x = 0; x < 5; x++) dm[x] = c[(x + 4) % 5] ^ rotl1(c[(x + 1) % 5]);
      for (int i = 0; i < 25; i++) push_exp(a[i] ^ dm[i % 5], i == 0);
   endfunction

   // Output monitor: samples mid-cycle, transfer happens at the next rising edge.
   always @(negedge clk) begin
      if (pushout) begin
         out_count++;
         if (sb.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("dout", dout, mon_e.d);
            check("firstout", {63'd0, firstout}, {63'd0, mon_e.f});
         end
      end
   end

   // Called right after the last lane's accepting edge; counts edges until LOAD is seen.
   task automatic wait_load(output int n);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (!stopin) return;
      end
      check("timeout_wait_load", 64'd0, 64'd1);
   endtask

   task automatic drive(input logic [63:0] d, input logic f);
      pushin  = 1'b1;
      firstin = f;
      din     = d;
      @(posedge clk);
      #1;
      pushin  = 1'b0;
      firstin = 1'b0;
   endtask

   task automatic send_frame(input frame_t a);
      for (int i = 0; i < 25; i++) drive(a[i], i == 0);
   endtask

   frame_t fr;
   int     n;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; pushin = 1'b0; firstin = 1'b0; din = '0; stopout = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stopin", {63'd0, stopin}, 64'd0);
      check("rst_pushout", {63'd0, pushout}, 64'd0);
      check("rst_m2wr", {63'd0, m2wr}, 64'd0);
      check("rst_m2rx", {61'd0, m2rx}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Non-first lanes before any firstin are dropped.
      for (int i = 0; i < 3; i++) begin
         drive(64'hDEAD_0000 + 64'(i), 1'b0);
         @(negedge clk);
         check("drop_m2wr", {63'd0, m2wr}, 64'd0);
         check("drop_stopin", {63'd0, stopin}, 64'd0);
         @(posedge clk); #1;
      end

      // All-zero frame.
      for (int i = 0; i < 25; i++) begin
         fr[i] = '0;
         push_exp(64'd0, i == 0);
      end
      send_frame(fr);
      @(negedge clk);
      check("calc_m2wr", {63'd0, m2wr}, 64'd1);
      check("calc_m2wxy", {58'd0, m2wy, m2wx}, {58'd0, 3'd4, 3'd4});
      check("calc_stopin", {63'd0, stopin}, 64'd1);
      wait_load(n);
      check("drain_len_zero", 64'(n), 64'd26);

      // Single bit at (0,0).
      for (int i = 0; i < 25; i++) begin
         fr[i] = (i == 0) ? 64'd1 : 64'd0;
         push_exp((i == 0 || i % 5 == 1) ? 64'd1 : (i % 5 == 4) ? 64'd2 : 64'd0, i == 0);
      end
      send_frame(fr);
      wait_load(n);
      check("drain_len_bit0", 64'(n), 64'd26);

      // MSB at (2,0): the rotate wraps into bit 0.
      for (int i = 0; i < 25; i++) begin
         fr[i] = (i == 2) ? 64'h8000_0000_0000_0000 : 64'd0;
         push_exp((i % 5 == 1) ? 64'd1 :
                  (i % 5 == 3 || i == 2) ? 64'h8000_0000_0000_0000 : 64'd0, i == 0);
      end
      send_frame(fr);
      wait_load(n);

      // Counting lanes with a 3-cycle stall on output lane 7.
      for (int i = 0; i < 25; i++) fr[i] = 64'(i + 1);
      push_model(fr);
      out_count = 0;
      send_frame(fr);
      fork
         begin
            repeat (8) @(posedge clk);
            #1 stopout = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check("stall_pushout", {63'd0, pushout}, 64'd0);
               check("stall_rxy", {58'd0, m2ry, m2rx}, {58'd0, 3'd1, 3'd2});
               @(posedge clk);
               #1;
            end
            stopout = 1'b0;
         end
         wait_load(n);
      join
      check("stall_drain_cycles", 64'(n - 1), 64'd28);
      check("stall_out_count", 64'(out_count), 64'd25);

      // Frame restarted by firstin at lane 10; only the second frame is output.
      for (int i = 0; i < 10; i++) drive({$urandom, $urandom}, i == 0);
      for (int i = 0; i < 25; i++) fr[i] = {$urandom, $urandom};
      push_model(fr);
      send_frame(fr);
      wait_load(n);
      check("drain_len_restart", 64'(n), 64'd26);

      // Reset while lane 12 is on the output.
      for (int i = 0; i < 25; i++) fr[i] = {$urandom, $urandom};
      push_model(fr);
      send_frame(fr);
      repeat (13) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      sb.delete();
      @(negedge clk);
      check("mid_rst_pushout", {63'd0, pushout}, 64'd0);
      check("mid_rst_stopin", {63'd0, stopin}, 64'd0);
      check("mid_rst_m2wr", {63'd0, m2wr}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Fresh frame after the reset.
      for (int i = 0; i < 25; i++) fr[i] = {$urandom, $urandom};
      push_model(fr);
      send_frame(fr);
      wait_load(n);
      check("drain_len_post_rst", 64'(n), 64'd26);

      repeat (2) @(posedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
